// File: rtl/floor_log2_pkg.sv
// Shared types and default sizes for the floor(log2) arbiter slice.
// Optional feature macro: FLOOR_LOG2_ZERO_FLAG_EN (zero-input flag / fast path).
package floor_log2_pkg;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int VAL_W_DEFAULT   = 19;
  localparam int OUT_W_DEFAULT   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [VAL_W_DEFAULT-1:0] val_t;

endpackage

// File: rtl/floor_log2_iter.sv
// Iterative floor(log2) engine: loads a value on start, then shifts right
// once per enabled cycle, counting shifts until only bit 0 can be set.
// done is combinational on the current shift register contents.
module floor_log2_iter
  import floor_log2_pkg::*;
#(
  parameter int VAL_W = VAL_W_DEFAULT,
  parameter int CNT_W = $clog2(VAL_W_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             run,
  input  logic [VAL_W-1:0] val_in,
  output logic             done,
  output logic [CNT_W-1:0] result
);

  logic [VAL_W-1:0] shreg;
  logic [CNT_W-1:0] count;

  // Finished once nothing above bit 0 remains; a zero value finishes immediately.
  assign done   = (shreg[VAL_W-1:1] == '0);
  assign result = count;

  // Load on start, otherwise shift and count while the arbiter keeps us running.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      count <= '0;
    end else if (start) begin
      shreg <= val_in;
      count <= '0;
    end else if (run && !done) begin
      shreg <= shreg >> 1;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/floor_log2_arbiter.sv
// Round-robin front end sharing one floor_log2_iter among NUM_REQ requesters.
// Optional feature macro: FLOOR_LOG2_ZERO_FLAG_EN adds rsp_zero and lets a zero
// value bypass the engine (response one cycle after acceptance).
//
// state | meaning
// IDLE  | arbitrating; req_ready one-hot at the round-robin winner
// BUSY  | engine shifting the captured value
// RESP  | result held on rsp_* until rsp_ready
module floor_log2_arbiter
  import floor_log2_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int VAL_W   = VAL_W_DEFAULT,
  parameter int OUT_W   = OUT_W_DEFAULT,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*VAL_W-1:0] req_val,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [OUT_W-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
`ifdef FLOOR_LOG2_ZERO_FLAG_EN
  output logic                     rsp_zero,
`endif
  output logic                     busy
);

  localparam int CNT_W = $clog2(VAL_W);

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id;
  logic [ID_W-1:0]  id_next;
  logic [ID_W:0]    cand;
  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic [VAL_W-1:0] grant_val;
  logic             iter_start;
  logic             iter_run;
  logic             iter_done;
  logic [CNT_W-1:0] iter_result;

  // Round-robin search: first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[ID_W-1:0];
      end
    end
  end

  // Accept only while idle; the grant is the acceptance, so it is one-hot.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_any) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign grant_val  = req_val[int'(grant_id)*VAL_W +: VAL_W];
  assign id_next    = (id == ID_W'(NUM_REQ-1)) ? '0 : id + 1'b1;
  assign iter_start = (state == IDLE) && grant_any;
  assign iter_run   = (state == BUSY);
  assign busy       = (state != IDLE);

  floor_log2_iter #(
    .VAL_W (VAL_W),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (iter_start),
    .run    (iter_run),
    .val_in (grant_val),
    .done   (iter_done),
    .result (iter_result)
  );

  // Arbiter FSM with registered response channel and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id        <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
`ifdef FLOOR_LOG2_ZERO_FLAG_EN
      rsp_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            id <= grant_id;
`ifdef FLOOR_LOG2_ZERO_FLAG_EN
            if (grant_val == '0) begin
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_id    <= grant_id;
              rsp_zero  <= 1'b1;
              state     <= RESP;
            end else begin
              state <= BUSY;
            end
`else
            state <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (iter_done) begin
            rsp_valid <= 1'b1;
            rsp_data  <= OUT_W'(iter_result);
            rsp_id    <= id;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= id_next;
`ifdef FLOOR_LOG2_ZERO_FLAG_EN
            rsp_zero  <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_floor_log2_arbiter.sv
// Directed self-checking bench for floor_log2_arbiter (NUM_REQ=4, VAL_W=19).
// Honours FLOOR_LOG2_ZERO_FLAG_EN when defined at compile time.
module tb_floor_log2_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [75:0] req_val;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
`ifdef FLOOR_LOG2_ZERO_FLAG_EN
  logic        rsp_zero;
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 2;
`endif

  int checks = 0;
  int errors = 0;

  floor_log2_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_val   (req_val),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
`ifdef FLOOR_LOG2_ZERO_FLAG_EN
    .rsp_zero  (rsp_zero),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rid;
    logic [18:0] v;
    int          exp_data;
    int          exp_lat;
    int          exp_zero;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Present one request (caller at a negedge, engine idle) and complete its handshake.
  task automatic issue(input int rid, input logic [18:0] v, input logic [3:0] exp_ready);
    req_val[rid*19 +: 19] = v;
    req_valid[rid] = 1'b1;
    #1;
    chk("grant", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
    req_valid[rid] = 1'b0;
  endtask

  // Count cycles from the handshake until rsp_valid, then check the response.
  task automatic wait_valid(input int eid, input int edata, input int elat, input int lat0);
    int lat;
    lat = lat0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 64);
    chk("rsp_latency", lat, elat);
    chk("rsp_data", rsp_data, edata);
    chk("rsp_id", 32'(rsp_id), eid);
  endtask

  // Optionally stall the response, then accept it; returns at the following negedge.
  task automatic accept(input int hold);
    logic [31:0] d0;
    logic [1:0]  i0;
    d0 = rsp_data;
    i0 = rsp_id;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_data", rsp_data, d0);
      chk("hold_id", 32'(rsp_id), 32'(i0));
      chk("hold_no_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("no_ready_at_rsp_hs", 32'(req_ready), 0);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int stale;
    int exp_id[5];
    int exp_d[5];

    vecs[0] = '{0, 19'h00001,  0,  2,    0};
    vecs[1] = '{0, 19'h40000, 18, 20,    0};
    vecs[2] = '{1, 19'h00002,  1,  3,    0};
    vecs[3] = '{3, 19'h00003,  1,  3,    0};
    vecs[4] = '{2, 19'h7FFFF, 18, 20,    0};
    vecs[5] = '{1, 19'h00400, 10, 12,    0};
    vecs[6] = '{3, 19'h05555, 14, 16,    0};
    vecs[7] = '{2, 19'h00000,  0, ZLAT,  1};
    exp_id = '{0, 1, 2, 3, 0};
    exp_d  = '{2, 3, 7, 18, 2};

    reset     = 1'b1;
    req_valid = '0;
    req_val   = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);

    // Single-requester vectors.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      issue(vecs[i].rid, vecs[i].v, 4'(1 << vecs[i].rid));
      wait_valid(vecs[i].rid, vecs[i].exp_data, vecs[i].exp_lat, 0);
`ifdef FLOOR_LOG2_ZERO_FLAG_EN
      chk("rsp_zero", 32'(rsp_zero), vecs[i].exp_zero);
`endif
      accept(0);
    end

    // All requesters continuously valid after reset: grants 0,1,2,3,0.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_val   = {19'h7FFFF, 19'd255, 19'd8, 19'd5};
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 300 && n < 5; c++) begin
      @(negedge clk);
      if (busy) chk("no_ready_while_busy", 32'(req_ready), 0);
      if (rsp_valid) begin
        chk("rr_id", 32'(rsp_id), exp_id[n]);
        chk("rr_data", rsp_data, exp_d[n]);
        n++;
        if (n == 5) req_valid = '0;
      end
    end
    chk("rr_count", n, 5);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_val   = '0;

    // Backpressure: hold rsp_ready low for 10 cycles while requester 0 waits.
    @(negedge clk);
    issue(1, 19'd8, 4'b0010);
    req_val[0 +: 19] = 19'd1;
    req_valid[0]     = 1'b1;
    wait_valid(1, 3, 5, 0);
    accept(10);
    #1;
    chk("grant_after_rsp_hs", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    wait_valid(0, 0, 2, 0);
    accept(0);

    // Requester 1 withdraws before grant; requester 3 wins from rr_ptr=1.
    @(negedge clk);
    issue(0, 19'h00100, 4'b0001);
    req_val[1*19 +: 19] = 19'd4;
    req_val[3*19 +: 19] = 19'h20;
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    repeat (3) @(negedge clk);
    req_valid[1] = 1'b0;
    wait_valid(0, 8, 10, 3);
    accept(0);
    #1;
    chk("grant_after_drop", 32'(req_ready), 32'b1000);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    wait_valid(3, 5, 7, 0);
    accept(0);

    // Reset during BUSY: aborts, no stale response, pointer back to 0.
    @(negedge clk);
    issue(1, 19'd1, 4'b0010);
    wait_valid(1, 0, 2, 0);
    accept(0);
    @(negedge clk);
    issue(2, 19'h10000, 4'b0100);
    repeat (5) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    stale = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    chk("abort_no_stale_rsp", stale, 0);
    req_val = '0;
    req_val[0 +: 19]    = 19'd4;
    req_val[3*19 +: 19] = 19'd2;
    req_valid = 4'b1001;
    #1;
    chk("grant_after_abort", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    wait_valid(0, 2, 4, 0);
    accept(0);
    #1;
    chk("grant_next_after_abort", 32'(req_ready), 32'b1000);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    wait_valid(3, 1, 3, 0);
    accept(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
